// File: rtl/ram_initiator_pkg.sv
// Shared FSM encoding and default sizing for the RAM initiator and its timer.
package ram_initiator_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LEN_WIDTH  = 4;
  localparam int DEF_TIMEOUT    = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_initiator_timer.sv
// Wait-cycle counter for one RAM access: cleared on issue, counts cycles
// without completion, flags the first wait cycle and the timeout cycle.
module ram_initiator_timer
  import ram_initiator_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic first_o,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The first wait cycle never completes, so it always increments: count 0 marks it.
  assign first_o  = (cnt_q == '0);
  assign expire_o = inc_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ram_initiator.sv
// Request/response front end for a handshaked RAM: single writes, read bursts,
// completion timeout, back-pressured responses.
module ram_initiator
  import ram_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  mem_beg,
  input  logic                  mem_rd,
  output logic                  busy
);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic                  we_q;
  logic                  last_q;
  logic                  err_q;

  logic accept;
  logic first_wait;
  logic done;
  logic timed_out;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign done   = (state_q == ST_WAIT) && mem_rd && !first_wait;

  ram_initiator_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q == ST_ISSUE),
    .inc_i    ((state_q == ST_WAIT) && !done),
    .first_o  (first_wait),
    .expire_o (timed_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (done || timed_out) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = last_q ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_beg   = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    case (state_q)
      ST_IDLE:  req_ready = 1'b1;
      ST_ISSUE: begin
        mem_beg = 1'b1;
        mem_we  = we_q;
        mem_oe  = ~we_q;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_last  = last_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_data  = rsp_data_q;

  // addr_q/wdata_q only change on entry to ISSUE, so they double as the held RAM bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          we_q    <= req_we;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          count_q <= (req_we || req_len == '0) ? LEN_WIDTH'(1) : req_len;
        end
        ST_WAIT: if (done) begin
          rsp_data_q <= we_q ? '0 : mem_rdata;
          last_q     <= (count_q == LEN_WIDTH'(1));
          err_q      <= 1'b0;
        end else if (timed_out) begin
          rsp_data_q <= '0;
          last_q     <= 1'b1;
          err_q      <= 1'b1;
        end
        ST_RESP: if (rsp_ready && !last_q) begin
          count_q <= count_q - LEN_WIDTH'(1);
          addr_q  <= addr_q + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_initiator.sv
// Directed and randomized bench for ram_initiator with a behavioural RAM and
// a transaction-level expectation model.
module tb_ram_initiator;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LW  = 4;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [LW-1:0] req_len;
  logic          rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_oe, mem_beg, mem_rd, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_initiator #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .mem_beg   (mem_beg),
    .mem_rd    (mem_rd)
  ,
    .busy      (busy)
  );

  // Power-on RAM content, a fixed function of the address.
  function automatic logic [15:0] seed(input logic [15:0] a);
    logic [31:0] h;
    if (a == 16'h0010) return 16'h1234;
    h = {16'h0, a} * 32'd40503 + 32'd7;
    return h[23:8];
  endfunction

  // Behavioural RAM: completion flag rises rd_delay cycles after the first
  // cycle following mem_beg; optionally a stale flag shows in that first cycle.
  logic [15:0] ram_w  [0:65535];
  bit          ram_ok [0:65535];
  logic [15:0] rd_word;
  int          since = 0;
  int          rd_delay = 1;
  bit          rd_tie0 = 1'b0;
  bit          rd_stale = 1'b0;

  always @(posedge clk) begin
    if (mem_beg) begin
      if (mem_we) begin
        ram_w[mem_addr]  <= mem_wdata;
        ram_ok[mem_addr] <= 1'b1;
      end
      rd_word <= ram_ok[mem_addr] ? ram_w[mem_addr] : seed(mem_addr);
      since   <= 1;
    end else if (since != 0 && since < 1000) begin
      since <= since + 1;
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_rdata = 16'hDEAD;
    if (!rd_tie0) begin
      if (since >= 1 + rd_delay) begin
        mem_rd    = 1'b1;
        mem_rdata = rd_word;
      end else if (since == 1 && rd_stale) begin
        mem_rd = 1'b1;
      end
    end
  end

  // Expected memory image, maintained from the request stream alone.
  logic [15:0] ref_mem [0:65535];
  bit          ref_ok  [0:65535];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs();
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_rsp_last",  32'(rsp_last),  32'd0);
    check("idle_rsp_err",   32'(rsp_err),   32'd0);
    check("idle_rsp_data",  32'(rsp_data),  32'd0);
    check("idle_mem_addr",  32'(mem_addr),  32'd0);
    check("idle_mem_wdata", 32'(mem_wdata), 32'd0);
    check("idle_mem_we",    32'(mem_we),    32'd0);
    check("idle_mem_oe",    32'(mem_oe),    32'd0);
    check("idle_mem_beg",   32'(mem_beg),   32'd0);
    check("idle_busy",      32'(busy),      32'd0);
  endtask

  // One request end to end; every DUT sample is taken on the falling edge.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [3:0] len, input int delay, input int hold,
                        input bit tie0, input bit hold_valid);
    int          n;
    int          cyc;
    logic [15:0] a;
    logic [15:0] exp_d;
    bit          last_exp;
    n        = we ? 1 : (len == 4'd0 ? 1 : int'(len));
    rd_delay = delay;
    rd_tie0  = tie0;
    rd_stale = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_len   = len;
    @(negedge clk);
    if (hold_valid) begin
      req_we    = ~we;
      req_addr  = ~addr;
      req_wdata = ~wdata;
      req_len   = 4'hF;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      a = addr + 16'(i);
      check("mem_beg", 32'(mem_beg), 32'd1);
      check("mem_addr", 32'(mem_addr), 32'(a));
      check("mem_we", 32'(mem_we), 32'(we));
      check("mem_oe", 32'(mem_oe), 32'(!we));
      if (we) begin
        check("mem_wdata", 32'(mem_wdata), 32'(wdata));
        ref_mem[a] = wdata;
        ref_ok[a]  = 1'b1;
      end
      exp_d    = (we || tie0) ? 16'h0 : (ref_ok[a] ? ref_mem[a] : seed(a));
      last_exp = (i == n - 1) || tie0;
      @(negedge clk);
      cyc = 1;
      while (!rsp_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("rsp_latency", 32'(cyc), tie0 ? 32'(TMO + 1) : 32'(delay + 2));
      if (hold_valid) check("req_ready_busy", 32'(req_ready), 32'd0);
      check("rsp_data", 32'(rsp_data), 32'(exp_d));
      check("rsp_last", 32'(rsp_last), 32'(last_exp));
      check("rsp_err", 32'(rsp_err), 32'(tie0));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_data", 32'(rsp_data), 32'(exp_d));
        check("hold_no_beg", 32'(mem_beg), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      if (tie0) break;
    end
    req_valid = 1'b0;
    check("busy_after", 32'(busy), 32'd0);
    $display("req we=%0d addr=%04h len=%0d delay=%0d hold=%0d tie0=%0d errors=%0d",
             we, addr, len, delay, hold, tie0, errors);
  endtask

  initial begin
    int          beg_cnt;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] base;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_len   = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs();

    do_req(1'b0, 16'h0010, 16'h0000, 4'd1, 1, 0, 1'b0, 1'b0);
    do_req(1'b1, 16'h0020, 16'hBEEF, 4'd0, 1, 0, 1'b0, 1'b0);
    do_req(1'b0, 16'h0020, 16'h0000, 4'd1, 2, 0, 1'b0, 1'b0);
    do_req(1'b0, 16'hFFFF, 16'h0000, 4'd3, 1, 1, 1'b0, 1'b0);
    do_req(1'b0, 16'h0030, 16'h0000, 4'd2, 1, 5, 1'b0, 1'b0);
    do_req(1'b0, 16'h0040, 16'h0000, 4'd2, 1, 1, 1'b1, 1'b0);

    // Reset in the first wait cycle of a four-word burst.
    @(negedge clk);
    rd_delay  = 2;
    rd_tie0   = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0100;
    req_len   = 4'd4;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_beg", 32'(mem_beg), 32'd1);
    @(negedge clk);
    check("rst_busy_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs();
    reset   = 1'b0;
    beg_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_beg) beg_cnt++;
    end
    check("rst_no_beg", 32'(beg_cnt), 32'd0);
    $display("reset mid-burst errors=%0d", errors);

    for (int t = 0; t < 24; t++) begin
      r_we   = 1'($urandom_range(0, 1));
      base   = ($urandom_range(0, 1) == 0) ? 16'hFFF8 : 16'h0040;
      r_addr = base + 16'($urandom_range(0, 7));
      do_req(r_we, r_addr, 16'($urandom), 4'($urandom_range(0, 5)),
             int'($urandom_range(1, 4)), int'($urandom_range(0, 2)),
             ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
